rand_sampler: RTL and testbench
===============================

RAND_SAMPLER -- requirements
Module: rand_sampler

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of FIFO entries, a power of two and at least 2.
REQ-002 SHALL have parameter PERIOD, default 1000: automatic sampling interval in clk cycles, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (asserted at 0).
REQ-005 SHALL have port rand_in, input, 8 bits: pseudorandom value from the upstream LFSR, sampled as-is.
REQ-006 SHALL have port en, input, 1 bit: enables periodic sampling.
REQ-007 SHALL have port trig, input, 1 bit: manual sample request, synchronous to clk, acted on at its rising edge.
REQ-008 SHALL have port out_data, output, 8 bits: oldest stored sample (FIFO head).
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid sample.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored samples.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a sample was dropped.
REQ-013 SHALL have port clr_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-014 SHALL keep an interval counter running 0..PERIOD-1 while en=1 and hold it at 0 while en=0.
- Tick: counter equals PERIOD-1 with en=1; counter then wraps to 0.
- First tick: PERIOD cycles after en rises.
REQ-015 SHALL detect a trig rising edge with a one-flop delay register (trig=1 while the previous trig=0), independent of en.
REQ-016 SHALL generate a push request in any cycle with a tick or a trig edge; both in the same cycle produce exactly one push.
REQ-017 SHALL, on a push, write the rand_in value present in that cycle into the FIFO tail.
REQ-018 SHALL pop the head in any cycle where out_valid=1 and out_ready=1.
REQ-019 SHALL accept a push when count<DEPTH, or when count=DEPTH and a pop occurs in the same cycle.
REQ-020 SHALL drop a push when count=DEPTH with no pop, leave FIFO contents unchanged, and set overflow.
REQ-021 SHALL update count as follows:
- +1 on accepted push only.
- -1 on pop only.
- unchanged on simultaneous push and pop.
REQ-022 SHALL behave as first-word-fall-through:
- out_valid = (count != 0).
- out_data driven from the head entry.
- A sample pushed into an empty FIFO appears on out_data with out_valid=1 the cycle after the push.
REQ-023 SHALL never pop when count=0; out_ready is ignored while out_valid=0.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL clear overflow when clr_ovf=1, except when an overflow event occurs in the same cycle, in which case set wins.

Reset
REQ-027 SHALL, while rst=0, immediately force the following regardless of clk:
- interval counter=0, trig delay flop=0.
- read and write pointers=0, count=0.
- out_valid=0, overflow=0, out_data=8'h00.
REQ-028 SHALL discard all stored samples on reset asserted mid-operation; the first tick after release occurs PERIOD cycles after the first en=1 clock edge.
REQ-029 SHALL perform no push or pop on the clock edge at which rst is sampled 0.

Verification (PERIOD=4, DEPTH=4)
REQ-030 SHALL check periodic sampling:
- Stimulus: en=1 from cycle 0, rand_in=cycle index, out_ready=0.
- Response: pushes at cycles 3,7,11,15 storing 3,7,11,15; count=4; out_data=3.
REQ-031 SHALL check overflow:
- Stimulus: continue the REQ-030 case to cycle 19.
- Response: push dropped; overflow=1; count=4; contents still 3,7,11,15.
- Then clr_ovf=1 for one cycle; overflow=0.
REQ-032 SHALL check drain:
- Stimulus: out_ready=1 with en=0.
- Response: out_data 3,7,11,15 on consecutive cycles; out_valid=0 and count=0 afterwards.
REQ-033 SHALL check simultaneous tick and trig edge:
- Stimulus: trig edge on a tick cycle with rand_in=8'hA5.
- Response: exactly one entry 8'hA5; count=1.
REQ-034 SHALL check full FIFO with simultaneous push and pop:
- Stimulus: count=4, out_ready=1, trig edge with rand_in=8'h5A.
- Response: count stays 4; overflow stays 0; 8'h5A becomes the last entry.
REQ-035 SHALL check reset mid-operation:
- Stimulus: rst=0 asynchronously with count=3.
- Response: count=0, out_valid=0, overflow=0 without waiting for a clk edge.

Source files
------------

// File: rtl/rand_sampler.sv
// rand_sampler: captures rand_in on a periodic tick or a trig rising edge into a
// first-word-fall-through FIFO with a sticky overflow flag.
module rand_sampler #(
  parameter int DEPTH  = 8,
  parameter int PERIOD = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rand_in,
  input  logic                     en,
  input  logic                     trig,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PERIOD);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trig_q;
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem [DEPTH];
  logic          tick, push_req, pop, full, push_ok, ovf_evt;
  always_comb begin
    tick     = en && cnt_q == LAST;
    cnt_d    = (!en || tick) ? '0 : cnt_q + 1'b1;
    push_req = tick || (trig && !trig_q);
    out_valid = count_q != '0;
    pop      = out_valid && out_ready;
    full     = count_q == FULL;
    push_ok  = push_req && (!full || pop);
    ovf_evt  = push_req && full && !pop;
    count_d  = (push_ok && !pop) ? count_q + 1'b1 :
               (pop && !push_ok) ? count_q - 1'b1 : count_q;
    ovf_d    = ovf_evt ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    out_data = out_valid ? mem[rd_q] : 8'h00;
    count    = count_q;
    overflow = ovf_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      trig_q  <= trig;
      rd_q    <= pop ? rd_q + 1'b1 : rd_q;
      wr_q    <= push_ok ? wr_q + 1'b1 : wr_q;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  // Storage needs no reset: out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wr_q] <= rand_in;
  end
endmodule

// File: tb/tb_rand_sampler.sv
// tb_rand_sampler: directed scoreboard bench for rand_sampler at PERIOD=4, DEPTH=4.
module tb_rand_sampler;
  logic       clk, rst, en, trig, out_ready, clr_ovf, out_valid, overflow;
  logic [7:0] rand_in, out_data;
  logic [2:0] count;
  int         checks, errors;
  logic [7:0] sb [$];

  rand_sampler #(.DEPTH(4), .PERIOD(4)) dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .en(en), .trig(trig),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic trig_push(input logic [7:0] v, input bit expect_store);
    rand_in = v;
    trig = 1'b1;
    if (expect_store) sb.push_back(v);
    cyc();
    trig = 1'b0;
    cyc();
  endtask

  // Monitor: every accepted output beat is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none at %0t", out_data, $time);
      end else begin
        chk("pop_data", {24'h0, out_data}, {24'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; en = 1'b0; trig = 1'b0; rand_in = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;
    #8;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(out_data), 0);

    // Periodic sampling: rand_in equals the cycle index.
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    sb.push_back(8'd3); sb.push_back(8'd7); sb.push_back(8'd11); sb.push_back(8'd15);
    for (int k = 0; k < 20; k++) begin
      cyc();
      rand_in = 8'(k + 1);
      if (k == 15) begin
        chk("per_count", 32'(count), 4);
        chk("per_head", 32'(out_data), 3);
        chk("per_ovf0", 32'(overflow), 0);
      end
    end
    en = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_head", 32'(out_data), 3);
    cyc(); clr_ovf = 1'b1;
    cyc(); clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 32'(overflow), 0);

    // Drain: 3,7,11,15 checked by the monitor.
    cyc(); out_ready = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_count", 32'(count), 0);
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_sb", sb.size(), 0);

    // Tick and trig edge in the same cycle: one entry.
    cyc(); en = 1'b1; rand_in = 8'h00;
    repeat (3) cyc();
    rand_in = 8'hA5; trig = 1'b1; sb.push_back(8'hA5);
    cyc(); trig = 1'b0; en = 1'b0; rand_in = 8'h00;
    @(negedge clk);
    chk("both_count", 32'(count), 1);
    chk("both_data", 32'(out_data), 32'hA5);

    // Full FIFO with push and pop together.
    cyc();
    trig_push(8'h11, 1'b1); trig_push(8'h22, 1'b1); trig_push(8'h33, 1'b1);
    @(negedge clk);
    chk("fill_count", 32'(count), 4);
    cyc(); out_ready = 1'b1; trig = 1'b1; rand_in = 8'h5A; sb.push_back(8'h5A);
    cyc(); out_ready = 1'b0; trig = 1'b0;
    @(negedge clk);
    chk("pp_count", 32'(count), 4);
    chk("pp_ovf", 32'(overflow), 0);
    cyc(); out_ready = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("pp_drain", 32'(count), 0);
    chk("pp_sb", sb.size(), 0);

    // Reset mid-operation with count=3 and overflow set.
    cyc();
    trig_push(8'h01, 1'b1); trig_push(8'h02, 1'b1); trig_push(8'h03, 1'b1); trig_push(8'h04, 1'b1);
    trig_push(8'h09, 1'b0);
    @(negedge clk);
    chk("pre_ovf", 32'(overflow), 1);
    cyc(); out_ready = 1'b1;
    cyc(); out_ready = 1'b0;
    @(negedge clk);
    chk("pre_count", 32'(count), 3);
    cyc(); #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_data", 32'(out_data), 0);
    sb.delete();

    // First tick after release comes PERIOD cycles after en.
    @(negedge clk);
    rst = 1'b1; en = 1'b1; rand_in = 8'h77;
    repeat (3) cyc();
    chk("rel_none", 32'(count), 0);
    sb.push_back(8'h77);
    cyc(); en = 1'b0;
    chk("rel_count", 32'(count), 1);
    chk("rel_data", 32'(out_data), 32'h77);
    out_ready = 1'b1;
    cyc(); out_ready = 1'b0;
    @(negedge clk);
    chk("rel_drain", 32'(count), 0);
    chk("end_sb", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
